// File: rtl/mem_access_unit.sv
// Load/store sequencer between the EX/MEM pipeline register and a word-wide,
// big-endian, synchronous-read data memory. Sub-word stores are performed as
// read-modify-write; sub-word loads are lane-extracted and sign/zero extended.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              load_valid,
  output logic [DATA_W-1:0] load_data,
  output logic              misaligned,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_memWrite,
  output logic              mem_memRead,
  input  logic [DATA_W-1:0] mem_readData
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_DONE = 3'd3,
    RMW_RD  = 3'd4,
    RMW_WR  = 3'd5
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] reqAddr_r;
  logic [DATA_W-1:0] reqWdata_r;
  logic [1:0]        reqSize_r;
  logic              reqSigned_r;
  logic              loadValid_r;
  logic [DATA_W-1:0] loadData_r;
  logic              misaligned_r;
  logic [ADDR_W-1:0] alignedAddr_s;

  // Word needs offset 00, half needs an even offset, byte goes anywhere; size 11 never.
  function automatic logic isAligned(input logic [1:0] size, input logic [1:0] lowAddr);
    logic ok;
    case (size)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~lowAddr[0];
      2'b10:   ok = (lowAddr == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Pick the addressed big-endian lane out of a memory word and extend it.
  function automatic logic [31:0] extractLoad(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] size, input logic sgn);
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic [31:0] result;
    case (off)
      2'b00:   laneByte = word[31:24];
      2'b01:   laneByte = word[23:16];
      2'b10:   laneByte = word[15:8];
      default: laneByte = word[7:0];
    endcase
    laneHalf = off[1] ? word[15:0] : word[31:16];
    case (size)
      2'b00:   result = {{24{sgn & laneByte[7]}}, laneByte};
      2'b01:   result = {{16{sgn & laneHalf[15]}}, laneHalf};
      default: result = word;
    endcase
    return result;
  endfunction

  // Replace the addressed big-endian lane of the old word with right-justified store data.
  function automatic logic [31:0] mergeStore(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] result;
    result = word;
    case (size)
      2'b00: begin
        case (off)
          2'b00:   result[31:24] = wdata[7:0];
          2'b01:   result[23:16] = wdata[7:0];
          2'b10:   result[15:8]  = wdata[7:0];
          default: result[7:0]   = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) begin
          result[15:0] = wdata[15:0];
        end else begin
          result[31:16] = wdata[15:0];
        end
      end
      default: result = wdata;
    endcase
    return result;
  endfunction

  assign alignedAddr_s = {reqAddr_r[ADDR_W-1:2], 2'b00};

  // Sequencer state, request capture and the registered load/misaligned pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      reqAddr_r    <= '0;
      reqWdata_r   <= '0;
      reqSize_r    <= 2'b00;
      reqSigned_r  <= 1'b0;
      loadValid_r  <= 1'b0;
      loadData_r   <= '0;
      misaligned_r <= 1'b0;
    end else begin
      loadValid_r  <= 1'b0;
      misaligned_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            if (!isAligned(req_size, req_addr[1:0])) begin
              misaligned_r <= 1'b1;
            end else begin
              reqAddr_r   <= req_addr;
              reqWdata_r  <= req_wdata;
              reqSize_r   <= req_size;
              reqSigned_r <= req_signed;
              if (!req_write) begin
                state_r <= RD;
              end else if (req_size == 2'b10) begin
                state_r <= WR;
              end else begin
                state_r <= RMW_RD;
              end
            end
          end else begin
            state_r <= IDLE;
          end
        end
        WR:      state_r <= IDLE;
        RD:      state_r <= RD_DONE;
        RD_DONE: begin
          loadData_r  <= extractLoad(mem_readData, reqAddr_r[1:0], reqSize_r, reqSigned_r);
          loadValid_r <= 1'b1;
          state_r     <= IDLE;
        end
        RMW_RD:  state_r <= RMW_WR;
        RMW_WR:  state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Memory-side strobes, address and write data decoded from the current state.
  always_comb begin
    mem_memRead   = 1'b0;
    mem_memWrite  = 1'b0;
    mem_address   = '0;
    mem_writeData = '0;
    case (state_r)
      WR: begin
        mem_memWrite  = 1'b1;
        mem_address   = alignedAddr_s;
        mem_writeData = reqWdata_r;
      end
      RD, RMW_RD: begin
        mem_memRead = 1'b1;
        mem_address = alignedAddr_s;
      end
      RMW_WR: begin
        mem_memWrite  = 1'b1;
        mem_address   = alignedAddr_s;
        mem_writeData = mergeStore(mem_readData, reqAddr_r[1:0], reqSize_r, reqWdata_r);
      end
      default: begin
        mem_memRead = 1'b0;
      end
    endcase
  end

  assign stall      = (state_r != IDLE);
  assign load_valid = loadValid_r;
  assign load_data  = loadData_r;
  assign misaligned = misaligned_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a byte-array reference memory and a
// per-request plan of expected cycles, compared against the DUT every cycle.
module tb_mem_access_unit;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        misaligned;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_memWrite;
  logic        mem_memRead;
  logic [31:0] mem_readData;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .load_valid(load_valid), .load_data(load_data), .misaligned(misaligned),
    .mem_address(mem_address), .mem_writeData(mem_writeData), .mem_memWrite(mem_memWrite),
    .mem_memRead(mem_memRead), .mem_readData(mem_readData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;
  logic [31:0] lastLoad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] initWord(input int i);
    return 32'h9E3779B9 * 32'(i + 1);
  endfunction

  // ---------------- synchronous-read RAM (64 words, byte addresses 0..0xFF)
  logic [31:0] ram [0:63];
  bit ramLoaded;
  always @(posedge clk) begin
    if (!reset_n && !ramLoaded) begin
      for (int i = 0; i < 64; i++) ram[i] <= initWord(i);
      ramLoaded <= 1'b1;
    end else begin
      if (mem_memWrite) ram[mem_address[7:2]] <= mem_writeData;
      if (mem_memRead) mem_readData <= ram[mem_address[7:2]];
    end
  end

  // ---------------- behavioural reference
  typedef struct {
    bit          stall;
    bit          rd;
    bit          wr;
    bit          lv;
    bit          mis;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ldata;
  } exp_t;

  logic [7:0] refMem [0:255];
  exp_t expQ[$];
  exp_t cur;
  bit modelReady;

  function automatic exp_t idleExp();
    exp_t e;
    e.stall = 1'b0; e.rd = 1'b0; e.wr = 1'b0; e.lv = 1'b0; e.mis = 1'b0;
    e.addr = 32'd0; e.wdata = 32'd0; e.ldata = 32'd0;
    return e;
  endfunction

  function automatic logic [31:0] refWord(input int base);
    return {refMem[base], refMem[base + 1], refMem[base + 2], refMem[base + 3]};
  endfunction

  // Expand one request into the cycles it must produce after its acceptance edge.
  task automatic plan(input bit w, input logic [1:0] sz, input bit sg,
                      input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int ia, n, base;
    logic [31:0] v;
    logic [7:0] tb4 [4];
    ia = int'(a & 32'hFF);
    base = ia & ~3;
    n = 1 << sz;
    if (sz == 2'b11 || (ia % n) != 0) begin
      e = idleExp(); e.mis = 1'b1; expQ.push_back(e);
    end else if (!w) begin
      v = 32'd0;
      for (int k = 0; k < n; k++) v = (v << 8) | 32'(refMem[ia + k]);
      if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
      e = idleExp(); e.stall = 1'b1; e.rd = 1'b1; e.addr = 32'(base); expQ.push_back(e);
      e = idleExp(); e.stall = 1'b1; expQ.push_back(e);
      e = idleExp(); e.lv = 1'b1; e.ldata = v; expQ.push_back(e);
    end else begin
      for (int k = 0; k < 4; k++) tb4[k] = refMem[base + k];
      for (int k = 0; k < n; k++) tb4[(ia & 3) + k] = 8'(d >> (8 * (n - 1 - k)));
      if (n != 4) begin
        e = idleExp(); e.stall = 1'b1; e.rd = 1'b1; e.addr = 32'(base); expQ.push_back(e);
      end
      e = idleExp(); e.stall = 1'b1; e.wr = 1'b1; e.addr = 32'(base);
      e.wdata = {tb4[0], tb4[1], tb4[2], tb4[3]};
      expQ.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      if (!modelReady) begin
        for (int i = 0; i < 256; i++) refMem[i] = 8'(initWord(i / 4) >> (8 * (3 - (i % 4))));
      end
      modelReady = 1'b1;
      expQ.delete();
      cur = idleExp();
    end else if (modelReady) begin
      if (req_valid && !cur.stall) plan(req_write, req_size, req_signed, req_addr, req_wdata);
      if (expQ.size() > 0) cur = expQ.pop_front();
      else cur = idleExp();
      if (cur.wr) begin
        for (int k = 0; k < 4; k++) refMem[int'(cur.addr & 32'hFC) + k] = 8'(cur.wdata >> (8 * (3 - k)));
      end
    end
  end

  // ---------------- per-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (modelReady) begin
      if (load_valid) lastLoad = load_data;
      chk("stall", 32'(stall), 32'(cur.stall));
      chk("mem_memRead", 32'(mem_memRead), 32'(cur.rd));
      chk("mem_memWrite", 32'(mem_memWrite), 32'(cur.wr));
      chk("load_valid", 32'(load_valid), 32'(cur.lv));
      chk("misaligned", 32'(misaligned), 32'(cur.mis));
      if (cur.rd || cur.wr) chk("mem_address", mem_address, cur.addr);
      if (cur.wr) chk("mem_writeData", mem_writeData, cur.wdata);
      if (cur.lv) chk("load_data", load_data, cur.ldata);
    end
  end

  // ---------------- stimulus helpers
  task automatic issue(input bit w, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] d);
    int waitCnt;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = d;
    waitCnt = 0;
    while (stall !== 1'b0 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    chk("accept_wait_bound", 32'(waitCnt < 20), 32'd1);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic checkResetVals(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_load_valid"}, 32'(load_valid), 32'd0);
    chk({tag, "_misaligned"}, 32'(misaligned), 32'd0);
    chk({tag, "_load_data"}, load_data, 32'd0);
    chk({tag, "_memWrite"}, 32'(mem_memWrite), 32'd0);
    chk({tag, "_memRead"}, 32'(mem_memRead), 32'd0);
    chk({tag, "_mem_address"}, mem_address, 32'd0);
    chk({tag, "_mem_writeData"}, mem_writeData, 32'd0);
  endtask

  initial begin
    bit w, sg;
    logic [1:0] sz;
    logic [31:0] a;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    checkResetVals("reset");
    reset_n = 1'b1;

    // word store then word load of the same word
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hAABBCCDD);
    idle(2);
    lastLoad = 32'hDEADBEEF;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    idle(4);
    chk("lw10", lastLoad, 32'hAABBCCDD);

    // byte store read-modify-write
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h00000055);
    idle(3);
    chk("ram20", ram[8], 32'h11553344);

    // sub-word loads with sign/zero extension
    issue(1'b1, 2'b10, 1'b0, 32'h30, 32'h80FF7F01);
    lastLoad = 32'hDEADBEEF; issue(1'b0, 2'b00, 1'b1, 32'h30, 32'd0); idle(4);
    chk("lb30", lastLoad, 32'hFFFFFF80);
    lastLoad = 32'hDEADBEEF; issue(1'b0, 2'b00, 1'b0, 32'h30, 32'd0); idle(4);
    chk("lbu30", lastLoad, 32'h00000080);
    lastLoad = 32'hDEADBEEF; issue(1'b0, 2'b01, 1'b1, 32'h32, 32'd0); idle(4);
    chk("lh32", lastLoad, 32'h00007F01);
    lastLoad = 32'hDEADBEEF; issue(1'b0, 2'b01, 1'b1, 32'h30, 32'd0); idle(4);
    chk("lh30", lastLoad, 32'hFFFF80FF);

    // misaligned and illegal requests
    issue(1'b0, 2'b10, 1'b0, 32'h31, 32'd0);
    issue(1'b1, 2'b01, 1'b0, 32'h23, 32'h1234);
    issue(1'b0, 2'b11, 1'b0, 32'h20, 32'd0);
    idle(2);
    chk("ram20_after_bad", ram[8], 32'h11553344);

    // back-to-back with req_valid held high
    lastLoad = 32'hDEADBEEF;
    issue(1'b1, 2'b00, 1'b0, 32'h40, 32'h000000AA);
    issue(1'b1, 2'b00, 1'b0, 32'h41, 32'h000000BB);
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'd0);
    idle(4);
    chk("b2b_top_half", {16'd0, lastLoad[31:16]}, 32'h0000AABB);

    // reset during RMW_RD abandons the sub-word store
    issue(1'b1, 2'b10, 1'b0, 32'h50, 32'h12345678);
    issue(1'b1, 2'b00, 1'b0, 32'h51, 32'h000000EE);
    @(negedge clk);
    reset_n = 1'b0; req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkResetVals("midreset");
    reset_n = 1'b1;
    idle(2);
    chk("ram50_unmodified", ram[20], 32'h12345678);
    lastLoad = 32'hDEADBEEF;
    issue(1'b0, 2'b10, 1'b0, 32'h50, 32'd0);
    idle(4);
    chk("lw50_after_reset", lastLoad, 32'h12345678);

    // randomized traffic against the reference
    for (int n = 0; n < 400; n++) begin
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
      issue(w, sz, sg, a, $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(4);

    for (int i = 0; i < 64; i++) chk("ram_final", ram[i], refWord(4 * i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer between the EX/MEM pipeline register and the word-wide data memory (synchronous read, big-endian, byte-addressed RAM).
- Converts byte, halfword and word loads/stores into word-aligned memory accesses.
- Performs read-modify-write for sub-word stores and sign- or zero-extension for sub-word loads.
- Stalls the pipeline while a multi-cycle access is in progress.

Parameters:
- ADDR_W, 32, width of request and memory address.
- DATA_W, 32, word width; fixed at 32 (byte-lane logic assumes 4 lanes).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req_valid  in  1  memory operation present in the MEM stage.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified for sub-word stores.
- stall  out  1  busy; requester holds its request while high.
- load_valid  out  1  one-cycle pulse; load_data is valid.
- load_data  out  32  extended load result, registered.
- misaligned  out  1  one-cycle pulse; request rejected.
- mem_address  out  32  to memory; always word-aligned (low 2 bits = 0).
- mem_writeData  out  32  to memory.
- mem_memWrite  out  1  to memory.
- mem_memRead  out  1  to memory.
- mem_readData  in  32  from memory; valid the cycle after a mem_memRead edge.

Behaviour:
- Byte lanes are big-endian.
  - Offset 0 maps to bits [31:24]; offset 3 maps to [7:0].
  - Half at offset 0 maps to [31:16]; half at offset 2 maps to [15:0].
- Alignment rules:
  - Word requires addr[1:0] = 00.
  - Half requires addr[0] = 0.
  - Byte may use any address.
- Request acceptance:
  - A request is accepted when req_valid = 1 and state = IDLE.
  - Address, data, size and signed are captured at that edge.
- stall = (state != IDLE), combinational. It is low in IDLE regardless of req_valid.
- Misaligned or size = 11:
  - The request is not accepted and no memory signal asserts.
  - misaligned = 1 the following cycle; state stays IDLE.
- FSM states and transitions:
  - IDLE:
    - word store -> WR
    - load -> RD
    - byte/half store -> RMW_RD
  - WR: mem_memWrite = 1, mem_address = addr, mem_writeData = wdata. Next state IDLE.
  - RD: mem_memRead = 1, mem_address = addr & ~3. Next state RD_DONE.
  - RD_DONE: extract the lane from mem_readData, extend per req_size and req_signed, and register into load_data. load_valid = 1 the following cycle. Next state IDLE.
  - RMW_RD: mem_memRead = 1 at the aligned address. Next state RMW_WR.
  - RMW_WR: mem_memWrite = 1 at the aligned address.
    - mem_writeData = mem_readData with the target lane replaced by wdata[7:0] (byte) or wdata[15:0] (half).
    - Next state IDLE.
- Memory-side outputs are combinational from state and the captured registers.
  - mem_memRead and mem_memWrite are never both high.
  - Both are 0 in IDLE.
- Latency, counted from the acceptance edge E0:
  - Word store: memory written at E1.
  - Load: load_valid high in the cycle after E2.
  - Sub-word store: memory written at E2.
  - stall is high for 1 cycle (word store) or 2 cycles (load, sub-word store).
- Back-to-back: a new request may be accepted on the edge on which state returns to IDLE. No idle bubble is required after that.
- Word load of a word just stored in the previous operation returns the new data. Memory write completes before the read is issued.
- Reset values (reset_n = 0):
  - state = IDLE.
  - stall = 0, load_valid = 0, misaligned = 0, load_data = 0.
  - mem_memWrite = 0, mem_memRead = 0, mem_address = 0, mem_writeData = 0.
- Reset mid-operation:
  - The operation is abandoned.
  - If reset is asserted in RMW_RD, or on the edge entering RMW_WR, the memory is left unmodified.
  - No load_valid pulse is produced for an abandoned load.
- load_valid and misaligned are never high in the same cycle.

Test Plan:
- Word store addr 0x10, data 0xAABBCCDD, then word load 0x10 -> mem_memWrite exactly 1 cycle; load_valid with load_data = 0xAABBCCDD; stall high 1 cycle then 2 cycles.
- Memory word 0x20 = 0x11223344; byte store 0x55 to 0x21 -> RMW read then write; word 0x20 becomes 0x11553344; mem_address = 0x20 in both cycles.
- Word 0x30 = 0x80FF7F01:
  - lb 0x30 -> 0xFFFFFF80.
  - lbu 0x30 -> 0x00000080.
  - lh 0x32 -> 0x00007F01.
  - lh 0x30 -> 0xFFFF80FF.
- Misaligned and illegal requests:
  - lw 0x31 -> misaligned pulse, no memRead/memWrite, stall 0.
  - sh 0x23 -> misaligned pulse, no memRead/memWrite, stall 0.
  - size = 11 -> misaligned pulse.
- Back-to-back sequence with req_valid held high: sb 0x40=0xAA, sb 0x41=0xBB, lw 0x40 -> all accepted without bubble; top half of the loaded word = 0xAABB.
- Sub-word store with reset_n = 0 during RMW_RD, old word 0x50 = 0x12345678 -> word 0x50 still 0x12345678; all outputs at reset values; next request accepted normally.
